// File: rtl/scalar_wb_arbiter.sv
// Round-robin arbiter for the scalar register-file write port (ALU, LD/ST, BRANCH).
// One holding buffer per functional unit feeds a registered writeback bundle.
module scalar_wb_arbiter #(
  parameter int NREQ   = 3,
  parameter int WORD_W = 32,
  parameter int REG_W  = 5
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*REG_W-1:0]    req_rd,
  input  logic [NREQ*WORD_W-1:0]   req_data,
  input  logic [NREQ-1:0]          req_spec,
  input  logic                     flush,
  output logic                     wb_s_rw_en,
  output logic [REG_W-1:0]         wb_s_rw,
  output logic [WORD_W-1:0]        wb_s_wdata,
  output logic                     wb_alu_done,
  output logic                     wb_load_done,
  output logic                     wb_br_done,
  output logic [1:0]               wb_grant_id,
  output logic [1:0]               dbg_rr_ptr
);

  logic [NREQ-1:0]   buf_v;
  logic [NREQ-1:0]   buf_spec;
  logic [REG_W-1:0]  buf_rd   [NREQ];
  logic [WORD_W-1:0] buf_data [NREQ];

  logic [1:0]        rr_ptr;
  logic [NREQ-1:0]   eligible;
  logic [NREQ-1:0]   grant;
  logic [1:0]        grant_idx;
  logic              grant_any;
  int                cand;

  // Handshake: FU i hands over its result on a rising edge where
  // req_valid[i] & req_ready[i]; ready depends only on buffer state and grant.
  assign req_ready  = ~buf_v | grant;
  assign dbg_rr_ptr = rr_ptr;

  // Speculative buffers are masked during a flush so they can never reach the port.
  always_comb begin
    eligible  = buf_v & ~(buf_spec & {NREQ{flush}});
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (int'(rr_ptr) + k) % NREQ;
      if (!grant_any && eligible[cand]) begin
        grant_any   = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand[1:0];
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      buf_v    <= '0;
      buf_spec <= '0;
      for (int i = 0; i < NREQ; i++) begin
        buf_rd[i]   <= '0;
        buf_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          buf_v[i]    <= !(flush && req_spec[i]);
          buf_spec[i] <= req_spec[i];
          buf_rd[i]   <= req_rd[i*REG_W +: REG_W];
          buf_data[i] <= req_data[i*WORD_W +: WORD_W];
        end else if (grant[i] || (flush && buf_spec[i])) begin
          buf_v[i] <= 1'b0;
        end
      end
    end
  end

  // Index/data/id hold their last value when nothing is granted.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rr_ptr       <= '0;
      wb_s_rw_en   <= 1'b0;
      wb_s_rw      <= '0;
      wb_s_wdata   <= '0;
      wb_grant_id  <= '0;
      wb_alu_done  <= 1'b0;
      wb_load_done <= 1'b0;
      wb_br_done   <= 1'b0;
    end else begin
      wb_alu_done  <= grant[0];
      wb_load_done <= grant[1];
      wb_br_done   <= grant[2];
      wb_s_rw_en   <= grant_any && (buf_rd[grant_idx] != '0);
      if (grant_any) begin
        wb_s_rw     <= buf_rd[grant_idx];
        wb_s_wdata  <= buf_data[grant_idx];
        wb_grant_id <= grant_idx;
        rr_ptr      <= (grant_idx == 2'(NREQ - 1)) ? 2'd0 : grant_idx + 2'd1;
      end
    end
  end

endmodule
